// File: rtl/guvm_wb_pkg.sv
// Types and constants shared by the GUVM wishbone feeder and its instruction queue.
package guvm_wb_pkg;

   localparam int unsigned WB_DW     = 128;
   localparam int unsigned WB_AW     = 32;
   localparam int unsigned LANE_W    = 32;
   localparam int unsigned WB_SW     = WB_DW / 8;
   localparam int unsigned LANE_SW   = LANE_W / 8;
   localparam int unsigned NUM_LANES = WB_DW / LANE_W;
   localparam int unsigned LANE_IW   = $clog2(NUM_LANES);

   // NOP returned in unselected lanes and on fetches from an empty queue
   localparam logic [LANE_W-1:0] FILL_WORD_DEF = 32'hF0081003;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } wb_state_t;

endpackage

// File: rtl/guvm_sync_fifo.sv
// Synchronous FIFO holding queued instructions; power-of-two depth so pointers wrap naturally.
module guvm_sync_fifo #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: only entries below r_count are ever observed
   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/guvm_wb_feeder.sv
// Wishbone slave feeding queued instructions to the core and capturing its stores.
// Optional out-of-window error response is enabled by defining GUVM_WB_ERR_EN.
module guvm_wb_feeder
   import guvm_wb_pkg::*;
#(
   parameter int unsigned       FIFO_DEPTH = 8,
   parameter logic [LANE_W-1:0] FILL_WORD  = FILL_WORD_DEF,
   parameter logic [WB_AW-1:0]  ADDR_BASE  = 32'h0000_0000,
   parameter logic [WB_AW-1:0]  ADDR_LIMIT = 32'h0000_FFFF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [WB_AW-1:0]  i_wb_adr,
   input  logic [WB_SW-1:0]  i_wb_sel,
   input  logic              i_wb_we,
   input  logic [WB_DW-1:0]  i_wb_dat,
   input  logic              i_wb_cyc,
   input  logic              i_wb_stb,
   output logic [WB_DW-1:0]  o_wb_dat,
   output logic              o_wb_ack,
   output logic              o_wb_err,
   input  logic [LANE_W-1:0] i_inst,
   input  logic              i_inst_valid,
   output logic              o_inst_ready,
   output logic [LANE_W-1:0] o_wdata,
   output logic [WB_AW-1:0]  o_wdata_addr,
   output logic              o_wdata_valid,
   output logic [15:0]       o_fetch_cnt,
   output logic              o_empty_fetch
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   wb_state_t          r_state;
   logic [LANE_W-1:0]  w_head;
   logic               w_full;
   logic               w_empty;
   logic [CNT_W-1:0]   w_count;
   logic               w_req;
   logic               w_in_range;
   logic               w_err_req;
   logic               w_pop;
   logic [LANE_IW-1:0] w_lane;
   logic [WB_DW-1:0]   w_rd_dat;
   logic [LANE_W-1:0]  w_st_word;
   logic [LANE_SW-1:0] w_st_sel;

   assign w_req      = (r_state == IDLE) & i_wb_cyc & i_wb_stb;
   assign w_lane     = i_wb_adr[3:2];
   assign w_in_range = ((i_wb_adr - ADDR_BASE) <= (ADDR_LIMIT - ADDR_BASE));

`ifdef GUVM_WB_ERR_EN
   assign w_err_req = ~w_in_range;
`else
   assign w_err_req = 1'b0;
   logic w_unused_range;
   assign w_unused_range = &{1'b0, w_in_range};
`endif

   logic w_unused_count;
   assign w_unused_count = &{1'b0, w_count};

   // Head leaves the queue on the edge that registers it into the ack cycle
   assign w_pop        = w_req & ~i_wb_we & ~w_err_req & ~w_empty;
   assign o_inst_ready = ~w_full;

   guvm_sync_fifo #(
      .WIDTH (LANE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_inst_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (i_inst_valid),
      .i_push_data (i_inst),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count)
   );

   // Lane steering: fetch data into the addressed lane, store data out of it with byte masking
   always_comb begin
      w_rd_dat  = {NUM_LANES{FILL_WORD}};
      w_st_word = '0;
      w_st_sel  = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         if (w_lane == LANE_IW'(k)) begin
            if (!w_empty) w_rd_dat[k*LANE_W +: LANE_W] = w_head;
            w_st_word = i_wb_dat[k*LANE_W +: LANE_W];
            w_st_sel  = i_wb_sel[k*LANE_SW +: LANE_SW];
         end
      end
      for (int b = 0; b < LANE_SW; b++) begin
         if (!w_st_sel[b]) w_st_word[b*8 +: 8] = 8'h00;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= IDLE;
         o_wb_dat      <= '0;
         o_wb_ack      <= 1'b0;
         o_wb_err      <= 1'b0;
         o_wdata       <= '0;
         o_wdata_addr  <= '0;
         o_wdata_valid <= 1'b0;
         o_fetch_cnt   <= '0;
         o_empty_fetch <= 1'b0;
      end else begin
         o_wb_ack      <= 1'b0;
         o_wb_err      <= 1'b0;
         o_wdata_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_state <= RESP;
                  if (w_err_req) begin
                     o_wb_err <= 1'b1;
                  end else begin
                     o_wb_ack <= 1'b1;
                     if (i_wb_we) begin
                        o_wdata       <= w_st_word;
                        o_wdata_addr  <= {i_wb_adr[WB_AW-1:2], 2'b00};
                        o_wdata_valid <= 1'b1;
                     end else begin
                        o_wb_dat    <= w_rd_dat;
                        o_fetch_cnt <= o_fetch_cnt + 16'd1;
                        if (w_empty) o_empty_fetch <= 1'b1;
                     end
                  end
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_guvm_wb_feeder.sv
// Directed self-checking bench for guvm_wb_feeder (covers GUVM_WB_ERR_EN either way).
module tb_guvm_wb_feeder;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic [31:0]  wb_adr;
   logic [15:0]  wb_sel;
   logic         wb_we;
   logic [127:0] wb_dat_w;
   logic         wb_cyc;
   logic         wb_stb;
   logic [127:0] wb_dat_r;
   logic         wb_ack;
   logic         wb_err;
   logic [31:0]  inst;
   logic         inst_valid;
   logic         inst_ready;
   logic [31:0]  wdata;
   logic [31:0]  wdata_addr;
   logic         wdata_valid;
   logic [15:0]  fetch_cnt;
   logic         empty_fetch;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [31:0] FILL = 32'hF0081003;

   always #5 clk = ~clk;

   guvm_wb_feeder dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_wb_adr      (wb_adr),
      .i_wb_sel      (wb_sel),
      .i_wb_we       (wb_we),
      .i_wb_dat      (wb_dat_w),
      .i_wb_cyc      (wb_cyc),
      .i_wb_stb      (wb_stb),
      .o_wb_dat      (wb_dat_r),
      .o_wb_ack      (wb_ack),
      .o_wb_err      (wb_err),
      .i_inst        (inst),
      .i_inst_valid  (inst_valid),
      .o_inst_ready  (inst_ready),
      .o_wdata       (wdata),
      .o_wdata_addr  (wdata_addr),
      .o_wdata_valid (wdata_valid),
      .o_fetch_cnt   (fetch_cnt),
      .o_empty_fetch (empty_fetch)
   );

   // Stimulus helpers: entered and left on a negedge
   task automatic push(input logic [31:0] w);
      inst = w; inst_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      inst_valid = 1'b0;
   endtask

   task automatic start_req(input logic [31:0] adr, input logic we, input logic [15:0] sel,
                            input logic [127:0] dat);
      wb_adr = adr; wb_we = we; wb_sel = sel; wb_dat_w = dat;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic end_req();
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_reset();
      n_checks++; if (wb_ack !== 1'b0) begin n_fails++; $display("FAIL rst_ack: got %0b want 0", wb_ack); end
      n_checks++; if (wb_err !== 1'b0) begin n_fails++; $display("FAIL rst_err: got %0b want 0", wb_err); end
      n_checks++; if (wb_dat_r !== 128'h0) begin n_fails++; $display("FAIL rst_dat: got %h want 0", wb_dat_r); end
      n_checks++; if ({wdata, wdata_addr, wdata_valid} !== 65'h0) begin n_fails++;
         $display("FAIL rst_wdata: got %h/%h/%0b want 0", wdata, wdata_addr, wdata_valid); end
      n_checks++; if (fetch_cnt !== 16'h0) begin n_fails++; $display("FAIL rst_cnt: got %0d want 0", fetch_cnt); end
      n_checks++; if (empty_fetch !== 1'b0) begin n_fails++; $display("FAIL rst_empty: got %0b want 0", empty_fetch); end
      n_checks++; if (inst_ready !== 1'b1) begin n_fails++; $display("FAIL rst_ready: got %0b want 1", inst_ready); end
   endtask

   task automatic test_fetch();
      push(32'hE3A01005);
      start_req(32'h0, 1'b0, 16'hFFFF, 128'h0);
      n_checks++; if (wb_ack !== 1'b1) begin n_fails++; $display("FAIL fetch_ack: got %0b want 1", wb_ack); end
      n_checks++; if (wb_dat_r !== 128'hF0081003_F0081003_F0081003_E3A01005) begin n_fails++;
         $display("FAIL fetch_dat: got %h want F0081003F0081003F0081003E3A01005", wb_dat_r); end
      n_checks++; if (fetch_cnt !== 16'd1) begin n_fails++; $display("FAIL fetch_cnt: got %0d want 1", fetch_cnt); end
      n_checks++; if (empty_fetch !== 1'b0) begin n_fails++; $display("FAIL fetch_empty: got %0b want 0", empty_fetch); end
      end_req();
      n_checks++; if (wb_ack !== 1'b0) begin n_fails++; $display("FAIL fetch_ack_drop: got %0b want 0", wb_ack); end
      push(32'h11112222);
      start_req(32'h28, 1'b0, 16'hFFFF, 128'h0);
      n_checks++; if (wb_dat_r !== 128'hF0081003_11112222_F0081003_F0081003) begin n_fails++;
         $display("FAIL fetch_lane2: got %h want F008100311112222F0081003F0081003", wb_dat_r); end
      n_checks++; if (fetch_cnt !== 16'd2) begin n_fails++; $display("FAIL fetch_cnt2: got %0d want 2", fetch_cnt); end
      end_req();
   endtask

   task automatic test_empty_fetch();
      start_req(32'h8, 1'b0, 16'hFFFF, 128'h0);
      n_checks++; if (wb_ack !== 1'b1) begin n_fails++; $display("FAIL empty_ack: got %0b want 1", wb_ack); end
      n_checks++; if (wb_dat_r !== {4{FILL}}) begin n_fails++; $display("FAIL empty_dat: got %h want all F0081003", wb_dat_r); end
      n_checks++; if (empty_fetch !== 1'b1) begin n_fails++; $display("FAIL empty_flag: got %0b want 1", empty_fetch); end
      n_checks++; if (fetch_cnt !== 16'd3) begin n_fails++; $display("FAIL empty_cnt: got %0d want 3", fetch_cnt); end
      end_req();
      n_checks++; if (empty_fetch !== 1'b1) begin n_fails++; $display("FAIL empty_sticky: got %0b want 1", empty_fetch); end
   endtask

   task automatic test_store();
      start_req(32'h104, 1'b1, 16'h00F0, 128'hAAAAAAAA_BBBBBBBB_DEADBEEF_CCCCCCCC);
      n_checks++; if (wb_ack !== 1'b1) begin n_fails++; $display("FAIL store_ack: got %0b want 1", wb_ack); end
      n_checks++; if (wdata !== 32'hDEADBEEF) begin n_fails++; $display("FAIL store_data: got %h want DEADBEEF", wdata); end
      n_checks++; if (wdata_addr !== 32'h104) begin n_fails++; $display("FAIL store_addr: got %h want 00000104", wdata_addr); end
      n_checks++; if (wdata_valid !== 1'b1) begin n_fails++; $display("FAIL store_valid: got %0b want 1", wdata_valid); end
      n_checks++; if (fetch_cnt !== 16'd3) begin n_fails++; $display("FAIL store_cnt: got %0d want 3", fetch_cnt); end
      end_req();
      n_checks++; if (wdata_valid !== 1'b0) begin n_fails++; $display("FAIL store_pulse: got %0b want 0", wdata_valid); end
      start_req(32'h10F, 1'b1, 16'h5000, 128'h12345678_00000000_00000000_00000000);
      n_checks++; if (wdata !== 32'h00340078) begin n_fails++; $display("FAIL store_mask: got %h want 00340078", wdata); end
      n_checks++; if (wdata_addr !== 32'h10C) begin n_fails++; $display("FAIL store_align: got %h want 0000010C", wdata_addr); end
      end_req();
   endtask

   task automatic test_fifo_full();
      logic [31:0] exp_q [8];
      exp_q = '{32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005,
                32'hA0000006, 32'hA0000007, 32'hC0000008, 32'hC0000009};
      for (int i = 0; i < 8; i++) push(32'hA0000000 + 32'(i));
      n_checks++; if (inst_ready !== 1'b0) begin n_fails++; $display("FAIL full_ready: got %0b want 0", inst_ready); end
      push(32'hBAD0BAD0);
      n_checks++; if (inst_ready !== 1'b0) begin n_fails++; $display("FAIL full_drop_ready: got %0b want 0", inst_ready); end
      start_req(32'h0, 1'b0, 16'hFFFF, 128'h0);
      n_checks++; if (wb_dat_r[31:0] !== 32'hA0000000) begin n_fails++; $display("FAIL full_head: got %h want A0000000", wb_dat_r[31:0]); end
      n_checks++; if (inst_ready !== 1'b1) begin n_fails++; $display("FAIL pop_ready: got %0b want 1", inst_ready); end
      end_req();
      // Push and pop on the same edge at depth 7
      inst = 32'hC0000008; inst_valid = 1'b1;
      start_req(32'h0, 1'b0, 16'hFFFF, 128'h0);
      inst_valid = 1'b0;
      n_checks++; if (wb_dat_r[31:0] !== 32'hA0000001) begin n_fails++; $display("FAIL pp_head: got %h want A0000001", wb_dat_r[31:0]); end
      n_checks++; if (inst_ready !== 1'b1) begin n_fails++; $display("FAIL pp_ready: got %0b want 1", inst_ready); end
      end_req();
      push(32'hC0000009);
      n_checks++; if (inst_ready !== 1'b0) begin n_fails++; $display("FAIL refill_ready: got %0b want 0", inst_ready); end
      for (int i = 0; i < 8; i++) begin
         start_req(32'h0, 1'b0, 16'hFFFF, 128'h0);
         n_checks++; if (wb_dat_r[31:0] !== exp_q[i]) begin n_fails++;
            $display("FAIL drain_%0d: got %h want %h", i, wb_dat_r[31:0], exp_q[i]); end
         end_req();
      end
      n_checks++; if (inst_ready !== 1'b1) begin n_fails++; $display("FAIL drain_ready: got %0b want 1", inst_ready); end
      n_checks++; if (fetch_cnt !== 16'd13) begin n_fails++; $display("FAIL drain_cnt: got %0d want 13", fetch_cnt); end
   endtask

   task automatic test_err();
      push(32'h00000077);
      start_req(32'h0001_0000, 1'b0, 16'hFFFF, 128'h0);
`ifdef GUVM_WB_ERR_EN
      n_checks++; if (wb_err !== 1'b1) begin n_fails++; $display("FAIL err_flag: got %0b want 1", wb_err); end
      n_checks++; if (wb_ack !== 1'b0) begin n_fails++; $display("FAIL err_ack: got %0b want 0", wb_ack); end
      n_checks++; if (fetch_cnt !== 16'd13) begin n_fails++; $display("FAIL err_cnt: got %0d want 13", fetch_cnt); end
      end_req();
      start_req(32'h0, 1'b0, 16'hFFFF, 128'h0);
`else
      n_checks++; if (wb_err !== 1'b0) begin n_fails++; $display("FAIL noerr_flag: got %0b want 0", wb_err); end
      n_checks++; if (wb_ack !== 1'b1) begin n_fails++; $display("FAIL noerr_ack: got %0b want 1", wb_ack); end
`endif
      n_checks++; if (wb_dat_r[31:0] !== 32'h00000077) begin n_fails++; $display("FAIL err_head: got %h want 00000077", wb_dat_r[31:0]); end
      n_checks++; if (fetch_cnt !== 16'd14) begin n_fails++; $display("FAIL err_cnt_after: got %0d want 14", fetch_cnt); end
      end_req();
   endtask

   task automatic test_reset_mid();
      push(32'h00000055);
      push(32'h00000066);
      start_req(32'h0, 1'b0, 16'hFFFF, 128'h0);
      n_checks++; if (wb_ack !== 1'b1 || wb_dat_r[31:0] !== 32'h55) begin n_fails++;
         $display("FAIL mid_pre: ack %0b dat %h want 1/00000055", wb_ack, wb_dat_r[31:0]); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (wb_ack !== 1'b0) begin n_fails++; $display("FAIL mid_ack: got %0b want 0", wb_ack); end
      n_checks++; if (wb_dat_r !== 128'h0 || fetch_cnt !== 16'h0 || empty_fetch !== 1'b0) begin n_fails++;
         $display("FAIL mid_regs: dat %h cnt %0d empty %0b want 0/0/0", wb_dat_r, fetch_cnt, empty_fetch); end
      n_checks++; if (inst_ready !== 1'b1) begin n_fails++; $display("FAIL mid_ready: got %0b want 1", inst_ready); end
      wb_cyc = 1'b0; wb_stb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (wb_ack !== 1'b0) begin n_fails++; $display("FAIL mid_noretry: got %0b want 0", wb_ack); end
      start_req(32'h0, 1'b0, 16'hFFFF, 128'h0);
      n_checks++; if (wb_dat_r !== {4{FILL}}) begin n_fails++; $display("FAIL mid_qclear: got %h want all F0081003", wb_dat_r); end
      n_checks++; if (fetch_cnt !== 16'd1) begin n_fails++; $display("FAIL mid_cnt: got %0d want 1", fetch_cnt); end
      end_req();
   endtask

   initial begin
      wb_adr = '0; wb_sel = '0; wb_we = 1'b0; wb_dat_w = '0;
      wb_cyc = 1'b0; wb_stb = 1'b0; inst = '0; inst_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_fetch();
      test_empty_fetch();
      test_store();
      test_fifo_full();
      test_err();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
